// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard/scoreboard unit: forwarding-select encodings
// and the multi-cycle scoreboard state enum.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        FW_RF = 2'b00,
        FW_M  = 2'b01,
        FW_W  = 2'b10
    } fw_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WB   = 2'b10
    } mc_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline side is the master,
// the hazard unit is the slave.
interface hazard_scoreboard_if #(
    parameter int NREG = 32,
    parameter int CNTW = 16
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   RA0_D, RA1_D, WA_D;
    logic            WEN_D, MC_D;
    logic [AW-1:0]   RA0_E, RA1_E, WA_E;
    logic            WEN_E, Load_E, MC_E, FLUSH_E;
    logic [AW-1:0]   WA_M, WA_W;
    logic            WEN_M, WEN_W;

    logic            PCWrite, FDWrite, DEFlush;
    logic [1:0]      FW1, FW2;
    logic            MC_BUSY, MC_WB;
    logic [AW-1:0]   MC_WA;
    logic [CNTW-1:0] STALL_CNT;

    modport master (
        output RA0_D, RA1_D, WA_D, WEN_D, MC_D,
        output RA0_E, RA1_E, WA_E, WEN_E, Load_E, MC_E, FLUSH_E,
        output WA_M, WA_W, WEN_M, WEN_W,
        input  PCWrite, FDWrite, DEFlush, FW1, FW2,
        input  MC_BUSY, MC_WB, MC_WA, STALL_CNT
    );

    modport slave (
        input  RA0_D, RA1_D, WA_D, WEN_D, MC_D,
        input  RA0_E, RA1_E, WA_E, WEN_E, Load_E, MC_E, FLUSH_E,
        input  WA_M, WA_W, WEN_M, WEN_W,
        output PCWrite, FDWrite, DEFlush, FW1, FW2,
        output MC_BUSY, MC_WB, MC_WA, STALL_CNT
    );

endinterface

// File: rtl/hazard_scoreboard_mc_scoreboard.sv
// Single-entry scoreboard for the multi-cycle unit: tracks the pending
// destination from issue in E until its writeback cycle.
module mc_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW     = 5,
    parameter int MC_LAT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          issue_i,
    input  logic [AW-1:0] wa_i,
    output logic          pending_o,
    output logic          in_busy_o,
    output logic          wb_o,
    output logic [AW-1:0] wa_o
);

    localparam int CW = (MC_LAT > 3) ? $clog2(MC_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MC_LAT - 2);

    mc_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] wa_q;
    logic          pending_q, busy_q, wb_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wa_q      <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            wb_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, WB: begin
                    if (issue_i) begin
                        wa_q      <= wa_i;
                        cnt_q     <= CNT_INIT;
                        pending_q <= 1'b1;
                        // With a 2-cycle unit there are no BUSY cycles: writeback follows issue directly.
                        if (MC_LAT == 2) begin
                            state_q <= WB;
                            busy_q  <= 1'b0;
                            wb_q    <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            busy_q  <= 1'b1;
                            wb_q    <= 1'b0;
                        end
                    end else begin
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b0;
                        wb_q      <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    // cnt_q counts remaining BUSY cycles; the last one hands over to WB.
                    if (cnt_q == CW'(1)) begin
                        state_q <= WB;
                        busy_q  <= 1'b0;
                        wb_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= 1'b0;
                    busy_q    <= 1'b0;
                    wb_q      <= 1'b0;
                end
            endcase
        end
    end

    assign pending_o = pending_q;
    assign in_busy_o = busy_q;
    assign wb_o      = wb_q;
    assign wa_o      = wa_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: load/MC-use stalls, scoreboard RAW/WAW and structural stalls,
// M/W forwarding selects and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int MC_LAT   = 4,
    parameter int ZERO_REG = 1,
    parameter int CNTW     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    hazard_scoreboard_if.slave hz
);

    localparam int AW = $clog2(NREG);

    logic            issue, pending, in_busy, mc_wb;
    logic            s1, s2, s3, stall;
    logic [AW-1:0]   mc_wa;
    logic [CNTW-1:0] cnt_q, cnt_d;

    function automatic logic hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a == b) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [1:0] fw_sel(input logic [AW-1:0] ra,
                                          input logic [AW-1:0] wa_m, input logic wen_m,
                                          input logic [AW-1:0] wa_w, input logic wen_w);
        if (!wen_m && hit(wa_m, ra)) return FW_M;
        if (!wen_w && hit(wa_w, ra)) return FW_W;
        return FW_RF;
    endfunction

    assign issue = hz.MC_E & ~hz.WEN_E & ~hz.FLUSH_E;

    mc_scoreboard #(
        .AW     (AW),
        .MC_LAT (MC_LAT)
    ) u_mc_scoreboard (
        .clk_i     (CLK),
        .rst_i     (RST),
        .issue_i   (issue),
        .wa_i      (hz.WA_E),
        .pending_o (pending),
        .in_busy_o (in_busy),
        .wb_o      (mc_wb),
        .wa_o      (mc_wa)
    );

    assign s1 = (hz.Load_E | hz.MC_E) & ~hz.WEN_E & ~hz.FLUSH_E
              & (hit(hz.WA_E, hz.RA0_D) | hit(hz.WA_E, hz.RA1_D));
    assign s2 = pending & (hit(mc_wa, hz.RA0_D) | hit(mc_wa, hz.RA1_D)
              | (~hz.WEN_D & hit(mc_wa, hz.WA_D)));
    assign s3 = hz.MC_D & (in_busy | issue);
    assign stall = s1 | s2 | s3;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign hz.PCWrite   = ~stall;
    assign hz.FDWrite   = ~stall;
    assign hz.DEFlush   = stall;
    assign hz.FW1       = fw_sel(hz.RA0_E, hz.WA_M, hz.WEN_M, hz.WA_W, hz.WEN_W);
    assign hz.FW2       = fw_sel(hz.RA1_E, hz.WA_M, hz.WEN_M, hz.WA_W, hz.WEN_W);
    assign hz.MC_BUSY   = pending;
    assign hz.MC_WB     = mc_wb;
    assign hz.MC_WA     = mc_wa;
    assign hz.STALL_CNT = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_hazard_scoreboard;

    localparam int NREG   = 32;
    localparam int MC_LAT = 4;
    localparam int CNTW   = 16;
    localparam int CMAX   = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(NREG), .CNTW(CNTW)) bus ();

    hazard_scoreboard #(
        .NREG     (NREG),
        .MC_LAT   (MC_LAT),
        .ZERO_REG (1),
        .CNTW     (CNTW)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .hz  (bus)
    );

    typedef struct {
        int ra0_d, ra1_d, wa_d, wen_d, mc_d;
        int ra0_e, ra1_e, wa_e, wen_e, load_e, mc_e, flush_e;
        int wa_m, wen_m, wa_w, wen_w;
        int st, fw1, fw2;
    } vec_t;

    vec_t tbl[$];

    // Reference model: the pending writeback is described by a valid flag,
    // its destination and the number of cycles left until its writeback cycle.
    bit m_valid = 0;
    int m_wa = 0;
    int m_left = 0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.RA0_D = '0; bus.RA1_D = '0; bus.WA_D = '0; bus.WEN_D = 1'b1; bus.MC_D = 1'b0;
        bus.RA0_E = '0; bus.RA1_E = '0; bus.WA_E = '0; bus.WEN_E = 1'b1;
        bus.Load_E = 1'b0; bus.MC_E = 1'b0; bus.FLUSH_E = 1'b0;
        bus.WA_M = '0; bus.WEN_M = 1'b1; bus.WA_W = '0; bus.WEN_W = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        bus.RA0_D = 5'(v.ra0_d); bus.RA1_D = 5'(v.ra1_d); bus.WA_D = 5'(v.wa_d);
        bus.WEN_D = 1'(v.wen_d); bus.MC_D = 1'(v.mc_d);
        bus.RA0_E = 5'(v.ra0_e); bus.RA1_E = 5'(v.ra1_e); bus.WA_E = 5'(v.wa_e);
        bus.WEN_E = 1'(v.wen_e); bus.Load_E = 1'(v.load_e); bus.MC_E = 1'(v.mc_e);
        bus.FLUSH_E = 1'(v.flush_e);
        bus.WA_M = 5'(v.wa_m); bus.WEN_M = 1'(v.wen_m);
        bus.WA_W = 5'(v.wa_w); bus.WEN_W = 1'(v.wen_w);
    endtask

    task automatic chk_stall(input string name, input int st);
        chk({name, "_pcwrite"}, 32'(bus.PCWrite), 32'(st == 0));
        chk({name, "_fdwrite"}, 32'(bus.FDWrite), 32'(st == 0));
        chk({name, "_deflush"}, 32'(bus.DEFlush), 32'(st != 0));
    endtask

    function automatic bit same(int a, int b);
        return (a == b) && (a != 0);
    endfunction

    function automatic int exp_fw(int ra);
        if (bus.WEN_M == 1'b0 && same(int'(bus.WA_M), ra)) return 1;
        if (bus.WEN_W == 1'b0 && same(int'(bus.WA_W), ra)) return 2;
        return 0;
    endfunction

    function automatic int exp_stall();
        int  ra0 = int'(bus.RA0_D);
        int  ra1 = int'(bus.RA1_D);
        bit  e_writes = (bus.WEN_E == 1'b0) && (bus.FLUSH_E == 1'b0);
        bit  e_issue  = e_writes && bus.MC_E;
        bit  busy     = m_valid && (m_left > 0);
        bit  st = 0;
        if (e_writes && (bus.Load_E || bus.MC_E) &&
            (same(int'(bus.WA_E), ra0) || same(int'(bus.WA_E), ra1))) st = 1;
        if (m_valid && (same(m_wa, ra0) || same(m_wa, ra1) ||
            (bus.WEN_D == 1'b0 && same(m_wa, int'(bus.WA_D))))) st = 1;
        if (bus.MC_D && (busy || e_issue)) st = 1;
        return int'(st);
    endfunction

    task automatic model_step(input int st);
        bit e_issue = (bus.MC_E == 1'b1) && (bus.WEN_E == 1'b0) && (bus.FLUSH_E == 1'b0);
        if (st != 0 && m_cnt < CMAX) m_cnt++;
        if (m_valid && m_left > 0) m_left--;
        else if (e_issue) begin
            m_valid = 1;
            m_wa    = int'(bus.WA_E);
            m_left  = MC_LAT - 2;
        end else m_valid = 0;
    endtask

    initial begin
        bit seen_wb;
        set_idle();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.MC_BUSY), 0);
        chk("rst_wb", 32'(bus.MC_WB), 0);
        chk("rst_wa", 32'(bus.MC_WA), 0);
        chk("rst_cnt", 32'(bus.STALL_CNT), 0);
        chk_stall("rst_idle", 0);
        chk("rst_fw1", 32'(bus.FW1), 0);
        chk("rst_fw2", 32'(bus.FW2), 0);

        // Combinational vectors, scoreboard held idle by reset
        tbl.push_back('{0,0,0,1,0, 0,0,0,1,0,0,0, 0,1,0,1, 0,0,0});
        tbl.push_back('{0,5,0,1,0, 0,0,5,0,1,0,0, 0,1,0,1, 1,0,0});
        tbl.push_back('{5,0,0,1,0, 0,0,5,0,1,0,0, 0,1,0,1, 1,0,0});
        tbl.push_back('{5,0,0,1,0, 0,0,5,1,1,0,0, 0,1,0,1, 0,0,0});
        tbl.push_back('{5,0,0,1,0, 0,0,5,0,1,0,1, 0,1,0,1, 0,0,0});
        tbl.push_back('{9,0,0,1,0, 0,0,9,0,0,1,0, 0,1,0,1, 1,0,0});
        tbl.push_back('{9,0,0,1,0, 0,0,9,0,0,1,1, 0,1,0,1, 0,0,0});
        tbl.push_back('{0,0,0,1,0, 0,0,0,0,1,0,0, 0,1,0,1, 0,0,0});
        tbl.push_back('{1,2,0,1,1, 0,0,3,0,0,1,0, 0,1,0,1, 1,0,0});
        tbl.push_back('{1,2,0,1,1, 0,0,3,1,0,1,0, 0,1,0,1, 0,0,0});
        tbl.push_back('{0,0,0,1,0, 7,0,0,1,0,0,0, 7,0,7,0, 0,1,0});
        tbl.push_back('{0,0,0,1,0, 7,0,0,1,0,0,0, 7,1,7,0, 0,2,0});
        tbl.push_back('{0,0,0,1,0, 0,0,0,1,0,0,0, 0,0,0,0, 0,0,0});
        tbl.push_back('{0,0,0,1,0, 3,4,0,1,0,0,0, 3,0,4,0, 0,1,2});
        tbl.push_back('{0,0,0,1,0, 0,4,0,1,0,0,0, 4,1,4,1, 0,0,0});
        tbl.push_back('{0,0,6,0,0, 0,0,6,0,1,0,0, 0,1,0,1, 0,0,0});
        foreach (tbl[i]) begin
            apply(tbl[i]);
            #1;
            chk_stall($sformatf("vec%0d", i), tbl[i].st);
            chk($sformatf("vec%0d_fw1", i), 32'(bus.FW1), 32'(tbl[i].fw1));
            chk($sformatf("vec%0d_fw2", i), 32'(bus.FW2), 32'(tbl[i].fw2));
        end

        tick();
        set_idle();
        rst = 1'b0;

        // Load-use: one stall cycle
        bus.Load_E = 1'b1; bus.WEN_E = 1'b0; bus.WA_E = 5'd5; bus.RA1_D = 5'd5;
        #1;
        chk_stall("lu", 1);
        tick();
        set_idle();
        #1;
        chk_stall("lu_after", 0);
        chk("lu_cnt", 32'(bus.STALL_CNT), 1);

        // MC RAW: mul to r9, dependent reader waits until the cycle after WB
        bus.MC_E = 1'b1; bus.WEN_E = 1'b0; bus.WA_E = 5'd9; bus.RA0_D = 5'd9;
        #1;
        chk_stall("raw_c0", 1);
        tick();
        bus.MC_E = 1'b0; bus.WEN_E = 1'b1;
        #1;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("raw_c%0d_busy", c), 32'(bus.MC_BUSY), 1);
            chk($sformatf("raw_c%0d_wb", c), 32'(bus.MC_WB), 32'(c == 3));
            chk($sformatf("raw_c%0d_wa", c), 32'(bus.MC_WA), 9);
            chk_stall($sformatf("raw_c%0d", c), 1);
            tick();
        end
        chk("raw_c4_busy", 32'(bus.MC_BUSY), 0);
        chk_stall("raw_c4", 0);
        chk("raw_cnt", 32'(bus.STALL_CNT), 5);

        // Structural: second MC in D waits until WB; then issue during WB
        set_idle();
        bus.MC_E = 1'b1; bus.WEN_E = 1'b0; bus.WA_E = 5'd10;
        bus.MC_D = 1'b1; bus.RA0_D = 5'd1; bus.RA1_D = 5'd2; bus.WA_D = 5'd3;
        #1;
        chk_stall("st_c0", 1);
        tick();
        bus.MC_E = 1'b0; bus.WEN_E = 1'b1;
        #1;
        for (int c = 1; c <= 2; c++) begin
            chk_stall($sformatf("st_c%0d", c), 1);
            tick();
        end
        chk("st_c3_wb", 32'(bus.MC_WB), 1);
        chk_stall("st_c3", 0);
        bus.MC_D = 1'b0;
        bus.MC_E = 1'b1; bus.WEN_E = 1'b0; bus.WA_E = 5'd11;
        #1;
        chk_stall("st_wbissue", 0);
        tick();
        set_idle();
        chk("b2b_busy", 32'(bus.MC_BUSY), 1);
        chk("b2b_wb", 32'(bus.MC_WB), 0);
        chk("b2b_wa", 32'(bus.MC_WA), 11);
        tick();
        tick();
        chk("b2b_wb_pulse", 32'(bus.MC_WB), 1);
        tick();
        chk("b2b_idle", 32'(bus.MC_BUSY), 0);
        chk("b2b_cnt", 32'(bus.STALL_CNT), 8);

        // Killed MC in E: no issue, no stall
        bus.MC_E = 1'b1; bus.WEN_E = 1'b0; bus.FLUSH_E = 1'b1; bus.WA_E = 5'd12; bus.RA0_D = 5'd12;
        #1;
        chk_stall("flush", 0);
        tick();
        set_idle();
        chk("flush_busy", 32'(bus.MC_BUSY), 0);
        chk("flush_cnt", 32'(bus.STALL_CNT), 8);

        // Reset while BUSY with count 1: entry dropped at once, no WB pulse
        bus.MC_E = 1'b1; bus.WEN_E = 1'b0; bus.WA_E = 5'd13;
        tick();
        set_idle();
        tick();
        chk("mrst_pre_busy", 32'(bus.MC_BUSY), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(bus.MC_BUSY), 0);
        chk("mrst_wa", 32'(bus.MC_WA), 0);
        chk("mrst_cnt", 32'(bus.STALL_CNT), 0);
        tick();
        rst = 1'b0;
        seen_wb = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.MC_WB) seen_wb = 1;
        end
        chk("mrst_no_wb", 32'(seen_wb), 0);

        // Randomized run against the reference model
        m_valid = 0; m_wa = 0; m_left = 0; m_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            int st;
            bus.RA0_D = 5'($urandom_range(0, 7)); bus.RA1_D = 5'($urandom_range(0, 7));
            bus.WA_D = 5'($urandom_range(0, 7)); bus.WEN_D = 1'($urandom_range(0, 1));
            bus.MC_D = ($urandom_range(0, 3) == 0);
            bus.RA0_E = 5'($urandom_range(0, 7)); bus.RA1_E = 5'($urandom_range(0, 7));
            bus.WA_E = 5'($urandom_range(0, 7)); bus.WEN_E = 1'($urandom_range(0, 1));
            bus.Load_E = ($urandom_range(0, 3) == 0); bus.MC_E = ($urandom_range(0, 3) == 0);
            bus.FLUSH_E = ($urandom_range(0, 7) == 0);
            bus.WA_M = 5'($urandom_range(0, 7)); bus.WEN_M = 1'($urandom_range(0, 1));
            bus.WA_W = 5'($urandom_range(0, 7)); bus.WEN_W = 1'($urandom_range(0, 1));
            #1;
            st = exp_stall();
            chk_stall("rnd", st);
            chk("rnd_fw1", 32'(bus.FW1), 32'(exp_fw(int'(bus.RA0_E))));
            chk("rnd_fw2", 32'(bus.FW2), 32'(exp_fw(int'(bus.RA1_E))));
            model_step(st);
            tick();
            chk("rnd_busy", 32'(bus.MC_BUSY), 32'(m_valid));
            chk("rnd_wb", 32'(bus.MC_WB), 32'(m_valid && m_left == 0));
            chk("rnd_wa", 32'(bus.MC_WA), 32'(m_wa));
            chk("rnd_cnt", 32'(bus.STALL_CNT), 32'(m_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline hazard unit. It combines three functions:
- load-use stall detection;
- M/W forwarding-select generation;
- a single-entry scoreboard for one multi-cycle execution unit (mul/div) with latency `MC_LAT`.

It sits between decode/execute and the pipeline-register enables. It also provides a saturating stall-cycle counter for performance analysis.

## Interface
Parameters:
- `NREG`, 32, architectural register count; `AW = $clog2(NREG)` is the address width.
- `MC_LAT`, 4, multi-cycle unit latency in cycles from issue in E to the writeback cycle (≥2).
- `ZERO_REG`, 1, if 1 then register 0 never matches for stall or forward.
- `CNTW`, 16, stall-counter width.

Ports (clock and reset first):
- `CLK` in 1: single clock.
- `RST` in 1: reset, asynchronous, active-high.
- `RA0_D`, `RA1_D` in AW: D-stage source addresses.
- `WA_D` in AW: D-stage destination address.
- `WEN_D` in 1: D-stage write enable, active-low.
- `MC_D` in 1: D-stage instruction is multi-cycle.
- `RA0_E`, `RA1_E` in AW: E-stage source addresses.
- `WA_E` in AW: E-stage destination address.
- `WEN_E` in 1: E-stage write enable, active-low.
- `Load_E` in 1: E-stage instruction is a load.
- `MC_E` in 1: E-stage instruction is multi-cycle.
- `FLUSH_E` in 1: E-stage instruction is being killed.
- `WA_M`, `WA_W` in AW: destination addresses in M and W.
- `WEN_M`, `WEN_W` in 1: write enables in M and W, active-low.
- `PCWrite`, `FDWrite` out 1: PC and F/D register enables.
- `DEFlush` out 1: insert a bubble into E.
- `FW1`, `FW2` out 2: forwarding select. 00 = register file, 01 = M, 10 = W, 11 = reserved (never driven).
- `MC_BUSY` out 1: scoreboard entry valid.
- `MC_WB` out 1: multi-cycle result is written to the register file this cycle.
- `MC_WA` out AW: pending multi-cycle destination.
- `STALL_CNT` out CNTW: saturating count of stall cycles.

## Operation
- Match rule: `a==b`, gated by `!(ZERO_REG && a==0)`.
- Stall conditions (any one asserts stall):
  - S1, load/MC-use: `(Load_E|MC_E) & !WEN_E & !FLUSH_E` and `WA_E` matches `RA0_D` or `RA1_D`.
  - S2, scoreboard RAW/WAW: state ≠ IDLE and `MC_WA` matches `RA0_D`, `RA1_D`, or (`!WEN_D` and `WA_D`).
  - S3, structural: `MC_D` and (state == BUSY, or a valid MC issue in E this cycle).
- On stall: `PCWrite=0`, `FDWrite=0`, `DEFlush=1`. Otherwise 1/1/0.
- Forwarding `FW1` (on `RA0_E`):
  - 01 if `!WEN_M` and `WA_M` matches;
  - else 10 if `!WEN_W` and `WA_W` matches;
  - else 00.
- Forwarding `FW2`: same rule on `RA1_E`. Each path is gated by its own stage's enable: M by `WEN_M`, W by `WEN_W`.
- FSM states:
  - IDLE → BUSY on valid issue (`MC_E & !WEN_E & !FLUSH_E`): latch `MC_WA=WA_E`, set `cnt=MC_LAT-2`.
  - BUSY: decrement `cnt`; at `cnt==0` go to WB.
  - WB: `MC_WB=1` for exactly one cycle; the register file is written at the closing edge. Go to IDLE, or to BUSY if a valid issue occurs in the same cycle (new `MC_WA` latched).
  - An MC instruction with `WEN_E=1` (no destination) never enters BUSY.
- `STALL_CNT` increments on every cycle the stall is asserted and saturates at all-ones.

## Timing
- `PCWrite`, `FDWrite`, `DEFlush`, `FW1`, `FW2` are combinational from inputs and current state.
- `MC_BUSY`, `MC_WB`, `MC_WA`, and `STALL_CNT` are registered.
- Issue at edge t puts the FSM in BUSY; `MC_WB` is high in cycle t+MC_LAT-1. A dependent D-stage instruction leaves D in the cycle after WB.
- Reset values: state IDLE, `MC_BUSY=0`, `MC_WB=0`, `MC_WA=0`, `STALL_CNT=0`. Combinational outputs settle to 1/1/0/00/00 when inputs are idle.
- Reset mid-operation: a reset in BUSY or WB discards the pending entry immediately; no `MC_WB` pulse is produced.
- `FLUSH_E` together with `MC_E`: no issue occurs, and S1 is suppressed for that cycle.

## Structure
- Shared package: FW encodings (`FW_RF`, `FW_M`, `FW_W`) and FSM state enum (IDLE/BUSY/WB).
- One sub-module, `mc_scoreboard`: contains the FSM, counter, and `MC_WA` register. It exports `pending`, `MC_WA`, and `MC_WB`. Stall/forward logic stays in the top level.

## Test plan
- Load-use: `Load_E=1`, `WEN_E=0`, `WA_E=5`, `RA1_D=5` → one cycle of `PCWrite=0`, `FDWrite=0`, `DEFlush=1`; `STALL_CNT` reads 1.
- Forward priority: `RA0_E=7`, `WA_M=7`, `WA_W=7`, both enables low → `FW1=01`. Then set `WEN_M=1` → `FW1=10`. With `RA0_E=0` and `ZERO_REG=1` → `FW1=00`.
- MC RAW with `MC_LAT=4`: issue a mul to r9; the next instruction reads r9 → stall for cycles 1–3 (cycle 3 is WB, `MC_WB=1`); the instruction proceeds in cycle 4.
- Structural/back-to-back: second MC in D while BUSY → stalled until WB. Issue in WB → FSM returns to BUSY and `MC_WA` is updated.
- `FLUSH_E` with `MC_E` → `MC_BUSY` stays 0 and no stall is caused.
- Reset mid-BUSY: assert `RST` at count 1 → `MC_BUSY=0` asynchronously, and no `MC_WB` pulse ever occurs.
